// File: rtl/fp_add_pipe_if.sv
// Operand/result handshake bundle for fp_add_pipe: valid/ready in and out plus packed operands and result fields.
interface fp_add_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   op;
  logic [EXP_W+MAN_W:0]   A_FP;
  logic [EXP_W+MAN_W:0]   B_FP;
  logic                   out_valid;
  logic                   out_ready;
  logic                   sign;
  logic [EXP_W-1:0]       exponent;
  logic [MAN_W-1:0]       mantissa;

  modport master (
    output in_valid, op, A_FP, B_FP, out_ready,
    input  in_ready, out_valid, sign, exponent, mantissa
  );

  modport slave (
    input  in_valid, op, A_FP, B_FP, out_ready,
    output in_ready, out_valid, sign, exponent, mantissa
  );
endinterface

// File: rtl/fp_add_pipe.sv
// 3-stage parametrised FP add/sub (align, add, normalise/round/pack) with a global stall.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_add_pipe_if.slave bus
);
  localparam int STAGES = 3;
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int MW     = MAN_W + 4;         // {1, man, G, R, S}
  localparam int SW     = MAN_W + 5;         // adder result incl. carry
  localparam int LZW    = $clog2(MW + 1);
  localparam int EW     = EXP_W + 2;         // room for under/overflow
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] DMAX = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_val;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] expo;
    logic [MW-1:0]    mbig;
    logic [MW-1:0]    msml;
  } s1_t;

  typedef struct packed {
    logic             spec;
    logic [W-1:0]     spec_val;
    logic             sign;
    logic [EXP_W-1:0] expo;
    logic [SW-1:0]    sum;
  } s2_t;

  logic [STAGES:1] r_vld_pipe;
  s1_t             r_s1, w_s1;
  s2_t             r_s2, w_s2;
  logic            r_sign;
  logic [EXP_W-1:0] r_exp;
  logic [MAN_W-1:0] r_man;
  logic            w_adv;

  assign w_adv         = !r_vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.sign      = r_sign;
  assign bus.exponent  = r_exp;
  assign bus.mantissa  = r_man;

  // ---------------- stage 1: unpack, specials, swap, align ----------------
  logic             w_a_s, w_b_s, w_a_big;
  logic [EXP_W-1:0] w_a_e, w_b_e, w_d;
  logic [MAN_W-1:0] w_a_m, w_b_m;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [MW-1:0]    w_sml_ext, w_sh, w_mask;

  always_comb begin
    w_a_s = bus.A_FP[W-1];
    w_a_e = bus.A_FP[W-2:MAN_W];
    w_a_m = bus.A_FP[MAN_W-1:0];
    w_b_s = bus.B_FP[W-1] ^ bus.op;
    w_b_e = bus.B_FP[W-2:MAN_W];
    w_b_m = bus.B_FP[MAN_W-1:0];

    // zero exponent field covers subnormals too: they are flushed
    w_a_zero = (w_a_e == '0);
    w_b_zero = (w_b_e == '0);
    w_a_inf  = (w_a_e == EMAX) && (w_a_m == '0);
    w_b_inf  = (w_b_e == EMAX) && (w_b_m == '0);
    w_a_nan  = (w_a_e == EMAX) && (w_a_m != '0);
    w_b_nan  = (w_b_e == EMAX) && (w_b_m != '0);

    w_a_big = {w_a_e, w_a_m} >= {w_b_e, w_b_m};

    w_s1      = '0;
    w_s1.sub  = w_a_s ^ w_b_s;
    w_s1.sign = w_a_big ? w_a_s : w_b_s;
    w_s1.expo = w_a_big ? w_a_e : w_b_e;
    w_s1.mbig = w_a_big ? {1'b1, w_a_m, 3'b000} : {1'b1, w_b_m, 3'b000};
    w_sml_ext = w_a_big ? {1'b1, w_b_m, 3'b000} : {1'b1, w_a_m, 3'b000};
    w_d       = w_a_big ? (w_a_e - w_b_e) : (w_b_e - w_a_e);

    w_sh   = w_sml_ext >> w_d;
    w_mask = ~({MW{1'b1}} << w_d);
    if (w_d >= DMAX)
      w_s1.msml = {{(MW-1){1'b0}}, 1'b1};  // hidden bit guarantees a set sticky
    else
      w_s1.msml = {w_sh[MW-1:1], w_sh[0] | (|(w_sml_ext & w_mask))};

    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_s != w_b_s))) begin
      w_s1.spec = 1'b1;  w_s1.spec_val = QNAN;
    end else if (w_a_inf) begin
      w_s1.spec = 1'b1;  w_s1.spec_val = {w_a_s, EMAX, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_s1.spec = 1'b1;  w_s1.spec_val = {w_b_s, EMAX, {MAN_W{1'b0}}};
    end else if (w_a_zero && w_b_zero) begin
      w_s1.spec = 1'b1;  w_s1.spec_val = {w_a_s & w_b_s, {(W-1){1'b0}}};
    end else if (w_a_zero) begin
      w_s1.spec = 1'b1;  w_s1.spec_val = {w_b_s, w_b_e, w_b_m};
    end else if (w_b_zero) begin
      w_s1.spec = 1'b1;  w_s1.spec_val = {w_a_s, w_a_e, w_a_m};
    end else if (w_s1.sub && ({w_a_e, w_a_m} == {w_b_e, w_b_m})) begin
      w_s1.spec = 1'b1;  w_s1.spec_val = '0;
    end
  end

  // ---------------- stage 2: magnitude add/sub ----------------
  always_comb begin
    w_s2          = '0;
    w_s2.spec     = r_s1.spec;
    w_s2.spec_val = r_s1.spec_val;
    w_s2.sign     = r_s1.sign;
    w_s2.expo     = r_s1.expo;
    w_s2.sum      = r_s1.sub ? ({1'b0, r_s1.mbig} - {1'b0, r_s1.msml})
                             : ({1'b0, r_s1.mbig} + {1'b0, r_s1.msml});
  end

  // ---------------- stage 3: normalise, round, pack ----------------
  logic [LZW-1:0]   w_lz;
  logic [MW-1:0]    w_m;
  logic [EW-1:0]    w_e;
  logic [MAN_W-1:0] w_frac;
  logic [W-1:0]     w_res;
  logic [3:0]       w_unused_bits;
`ifdef FP_ADD_RNE_EN
  logic             w_rnd;
  logic [MAN_W:0]   w_man_r;
`endif

  always_comb begin
    w_lz = LZW'(MW);
    for (int i = 0; i < MW; i++)
      if (r_s2.sum[i]) w_lz = LZW'(MW - 1 - i);
  end

  always_comb begin
    if (r_s2.sum[SW-1]) begin
      w_m = {r_s2.sum[SW-1:2], r_s2.sum[1] | r_s2.sum[0]};
      w_e = {2'b00, r_s2.expo} + EW'(1);
    end else begin
      w_m = r_s2.sum[MW-1:0] << w_lz;
      w_e = {2'b00, r_s2.expo} - {{(EW-LZW){1'b0}}, w_lz};
    end
    w_unused_bits = {w_m[MW-1], w_m[2:0]};

`ifdef FP_ADD_RNE_EN
    w_rnd   = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_man_r = {1'b0, w_m[MW-2:3]} + {{MAN_W{1'b0}}, w_rnd};
    // carry out leaves the fraction at zero, only the exponent moves
    if (w_man_r[MAN_W]) w_e = w_e + EW'(1);
    w_frac  = w_man_r[MAN_W-1:0];
`else
    w_frac  = w_m[MW-2:3];
`endif

    if (r_s2.spec)
      w_res = r_s2.spec_val;
    else if ((r_s2.sum == '0) || ($signed(w_e) <= 0))
      w_res = {r_s2.sign, {(W-1){1'b0}}};
    else if ($signed(w_e) >= $signed({2'b00, EMAX}))
      w_res = {r_s2.sign, EMAX, {MAN_W{1'b0}}};
    else
      w_res = {r_s2.sign, w_e[EXP_W-1:0], w_frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_man      <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], bus.in_valid};
      r_s1       <= w_s1;
      r_s2       <= w_s2;
      {r_sign, r_exp, r_man} <= w_res;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed-vector bench for fp_add_pipe: scoreboard queue of hand-computed results, latency, stall and reset checks.
module tb_fp_add_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_pipe_if bus ();
  fp_add_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_rx  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  int          acc_q[$];
  bit          lat_q[$];
  bit          held = 1'b0;
  logic [31:0] held_val;
  logic [31:0] w_res;
  assign w_res = {bus.sign, bus.exponent, bus.mantissa};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // called at a negedge; returns at the negedge after acceptance
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                      input logic [31:0] e, input bit lat);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.A_FP = a;
    bus.B_FP = b;
    bus.op   = o;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 0, 1);
    else begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
      lat_q.push_back(lat);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] e;
    int          a;
    bit          l;
    #2;
    if (rst_n && bus.out_valid) begin
      if (bus.out_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          l = lat_q.pop_front();
          chk("result", w_res, e);
          if (l) chk("latency", cyc + 1 - a, 3);
          n_rx++;
        end
      end else begin
        chk("stall_in_ready", bus.in_ready, 0);
        if (held) chk("stall_hold", w_res, held_val);
        held     = 1'b1;
        held_val = w_res;
      end
    end else held = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rx0;
    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.A_FP      = '0;
    bus.B_FP      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_outputs", w_res, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1);

    // basic, subtraction/sign, rounding, specials: back-to-back
    send(32'h40E80000, 32'h3EC00000, 1'b0, 32'h40F40000, 1'b1);
    send(32'h40C00000, 32'h40E00000, 1'b0, 32'h41500000, 1'b1);
    send(32'h40E00000, 32'h40400000, 1'b1, 32'h40800000, 1'b1);
    send(32'h42820000, 32'hC27C0000, 1'b0, 32'h40000000, 1'b1);
    send(32'hC0E00000, 32'hC0400000, 1'b0, 32'hC1200000, 1'b1);
`ifdef FP_ADD_RNE_EN
    send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b1);
`else
    send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 1'b1);
`endif
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1);
    send(32'h40400000, 32'hC0400000, 1'b0, 32'h00000000, 1'b1);
    send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b1);
    send(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b1);
    drain();

    // back-pressure: out_ready low for 4 cycles mid-stream
    rx0 = n_rx;
    fork
      begin
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0);
        send(32'h40E80000, 32'h3EC00000, 1'b0, 32'h40F40000, 1'b0);
        send(32'h40C00000, 32'h40E00000, 1'b0, 32'h41500000, 1'b0);
        send(32'h40E00000, 32'h40400000, 1'b1, 32'h40800000, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", n_rx - rx0, 5);

    // reset with two operations in flight
    send(32'h40C00000, 32'h40E00000, 1'b0, 32'h41500000, 1'b1);
    send(32'h40E00000, 32'h40400000, 1'b1, 32'h40800000, 1'b1);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_outputs", w_res, 0);
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 1);
    rx0 = n_rx;
    repeat (10) @(negedge clk);
    chk("midrst_no_stale", n_rx - rx0, 0);
    send(32'hC0E00000, 32'hC0400000, 1'b0, 32'hC1200000, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
